// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read port and flags.
// Optional sticky overflow/underflow flags via SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc)
         count_nxt = count + CW'(1);
      else if (rd_acc && !wr_acc)
         count_nxt = count - CW'(1);
   end

   // storage is never reset
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_acc) begin
            rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
            rd_data <= mem[rd_ptr];
         end
         rd_valid     <= rd_acc;
         count        <= count_nxt;
         full         <= (count_nxt == DEPTH_C);
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= AF_C);
         almost_empty <= (count_nxt <= AE_C);
      end
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full)
            overflow <= 1'b1;
         if (rd_en && empty)
            underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (16x8, AF=14, AE=2).
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int total = 0;
   int bad   = 0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   sync_fifo_param #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(4),
      .AF_THRESH(14),
      .AE_THRESH(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      step();
      step();
      total++;
      if ({count, empty, full, almost_empty, almost_full} !== {5'd0, 4'b1010}) begin
         bad++;
         $display("FAIL reset_flags got=%0h exp=%0h",
                  {count, empty, full, almost_empty, almost_full}, {5'd0, 4'b1010});
      end
      total++;
      if ({rd_data, rd_valid, overflow, underflow} !== 11'd0) begin
         bad++;
         $display("FAIL reset_out got=%0h exp=0", {rd_data, rd_valid, overflow, underflow});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
         total++;
         if (count !== 5'(i + 1) || almost_empty !== (i + 1 <= 2)
             || almost_full !== (i + 1 >= 14) || full !== (i == 15) || empty !== 1'b0) begin
            bad++;
            $display("FAIL fill_%0d got cnt=%0d ae=%b af=%b f=%b e=%b exp cnt=%0d",
                     i, count, almost_empty, almost_full, full, empty, i + 1);
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_overflow();
      wr_en = 1'b1; wr_data = 8'hAA;
      step();
      wr_en = 1'b0;
      step();
      total++;
      if (count !== 5'd16 || full !== 1'b1 || overflow !== ERR_EN) begin
         bad++;
         $display("FAIL overflow got cnt=%0d f=%b ovf=%b exp cnt=16 f=1 ovf=%b",
                  count, full, overflow, ERR_EN);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         step();
         total++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(i) || count !== 5'(15 - i)) begin
            bad++;
            $display("FAIL drain_%0d got v=%b d=%0h cnt=%0d exp v=1 d=%0h cnt=%0d",
                     i, rd_valid, rd_data, count, i, 15 - i);
         end
      end
      rd_en = 1'b0;
      step();
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h0F || empty !== 1'b1
          || count !== 5'd0 || overflow !== ERR_EN) begin
         bad++;
         $display("FAIL drain_end got v=%b d=%0h e=%b cnt=%0d ovf=%b exp v=0 d=f e=1 cnt=0",
                  rd_valid, rd_data, empty, count, overflow);
      end
   endtask

   task automatic test_simul_empty();
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
      step();
      total++;
      if (rd_valid !== 1'b0 || count !== 5'd1 || empty !== 1'b0
          || underflow !== ERR_EN) begin
         bad++;
         $display("FAIL simul_empty got v=%b cnt=%0d e=%b udf=%b exp v=0 cnt=1 e=0 udf=%b",
                  rd_valid, count, empty, underflow, ERR_EN);
      end
      wr_en = 1'b0;
      step();
      rd_en = 1'b0;
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h55 || count !== 5'd0
          || underflow !== ERR_EN) begin
         bad++;
         $display("FAIL simul_read got v=%b d=%0h cnt=%0d udf=%b exp v=1 d=55 cnt=0",
                  rd_valid, rd_data, count, underflow);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h20 + i);
         step();
      end
      wr_en = 1'b0;
      total++;
      if (count !== 5'd10 || almost_full !== 1'b0 || almost_empty !== 1'b0) begin
         bad++;
         $display("FAIL wrap_w10 got cnt=%0d af=%b ae=%b exp cnt=10 af=0 ae=0",
                  count, almost_full, almost_empty);
      end
      for (int i = 0; i < 10; i++) begin
         rd_en = 1'b1;
         step();
         total++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(8'h20 + i)) begin
            bad++;
            $display("FAIL wrap_r10_%0d got v=%b d=%0h exp v=1 d=%0h",
                     i, rd_valid, rd_data, 8'h20 + i);
         end
      end
      rd_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h30 + i);
         step();
      end
      wr_en = 1'b0;
      total++;
      if (count !== 5'd12) begin
         bad++;
         $display("FAIL wrap_w12 got cnt=%0d exp 12", count);
      end
      for (int i = 0; i < 12; i++) begin
         rd_en = 1'b1;
         step();
         total++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(8'h30 + i)) begin
            bad++;
            $display("FAIL wrap_r12_%0d got v=%b d=%0h exp v=1 d=%0h",
                     i, rd_valid, rd_data, 8'h30 + i);
         end
      end
      rd_en = 1'b0;
      step();
      total++;
      if (empty !== 1'b1 || count !== 5'd0) begin
         bad++;
         $display("FAIL wrap_end got e=%b cnt=%0d exp e=1 cnt=0", empty, count);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h40 + i);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h45 + i);
         step();
         total++;
         if (count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== 8'(8'h40 + i)) begin
            bad++;
            $display("FAIL stream_%0d got cnt=%0d v=%b d=%0h exp cnt=5 v=1 d=%0h",
                     i, count, rd_valid, rd_data, 8'h40 + i);
         end
      end
      rst_n = 1'b0;
      step();
      total++;
      if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0
          || overflow !== 1'b0 || underflow !== 1'b0) begin
         bad++;
         $display("FAIL stream_rst got cnt=%0d e=%b v=%b ovf=%b udf=%b exp 0 1 0 0 0",
                  count, empty, rd_valid, overflow, underflow);
      end
      rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
      step();
      total++;
      if (count !== 5'd0 || rd_valid !== 1'b0 || empty !== 1'b1) begin
         bad++;
         $display("FAIL post_rst got cnt=%0d v=%b e=%b exp 0 0 1", count, rd_valid, empty);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_simul_empty();
      test_wrap();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO: the next generation of the team's 16x4 dual-port FIFO storage. Data width and depth are configurable.
- Wraps internal dual-port storage with write/read pointers, an occupancy count, full/empty and almost-full/almost-empty flags, and a registered read port with a valid strobe.
- Sits between a producer and consumer in the same clock domain. Replaces ad-hoc pointer logic around fixed-size memories.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries (derived, not overridable).
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  sole clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  one-cycle strobe: rd_data holds a newly read word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky error flag (optional feature).
- underflow  output  1  sticky error flag (optional feature).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n low at a clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Storage contents are not cleared.
  - Reset mid-operation discards all entries and any read in flight; rd_valid is 0 in the cycle after reset.
- Accept rules:
  - Write accepted iff wr_en && !full. The word is stored at wr_ptr, and wr_ptr increments.
  - Read accepted iff rd_en && !empty. rd_data loads storage[rd_ptr], rd_ptr increments, and rd_valid=1 next cycle.
- Read latency: 1 cycle from an accepted rd_en edge to rd_data/rd_valid. rd_data holds its last value when no read is accepted; it is never forced to 0.
- Pointers: ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally.
- Count:
  - Increments on write-only accept, decrements on read-only accept.
  - Unchanged on simultaneous accepts, or when nothing is accepted.
- Flags: all flags are registered, derived from next-state count, so they are coherent with count every cycle.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write dropped. The write is not retried; the producer must observe full.
  - Empty: write accepted, read rejected. There is no write-to-read bypass; data is readable at the earliest the cycle after it is written.
- Write and read at the same address in one cycle can occur only when count is 0 or DEPTH. Both cases are excluded by the accept rules, so no read-during-write hazard exists.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any cycle with wr_en && full.
  - underflow sets on any cycle with rd_en && empty.
  - Both are sticky until rst_n low.
  - Neither affects FIFO state.
- Undefined: overflow and underflow are tied to 0, with no error logic. Ports remain present so the port list is macro-independent.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=4, AF_THRESH=14, AE_THRESH=2):
- Reset, then write 0x00..0x0F on 16 consecutive cycles:
  - almost_empty drops when count=3; almost_full rises when count=14.
  - full=1 and count=16 after the 16th write; empty=0.
- From full, drive wr_en with 0xAA for 1 cycle: count stays 16, contents unchanged. With the macro defined, overflow=1 and stays 1.
- From full, read 16 times:
  - rd_data sequence 0x00..0x0F, each one cycle after rd_en, with rd_valid=1 for each.
  - empty=1 and count=0 at the end; rd_data holds 0x0F afterwards.
- Empty FIFO, wr_en+rd_en same cycle with 0x55:
  - Read rejected, rd_valid=0, count=1.
  - Read next cycle returns 0x55; underflow=1 with the macro defined.
- Wrap-around:
  - Write 10, read 10, then write 12 words 0x30..0x3B.
  - Pointers wrap past 15; reads return 0x30..0x3B in order.
- Steady-state streaming with wr_en=rd_en=1 at count=5 for 20 cycles: count stays 5, FIFO order preserved. Assert rst_n low mid-stream: next cycle count=0, empty=1, rd_valid=0.
